// File: rtl/convo_core.sv
`timescale 1ns/1ps
// convo_core
//   3x3 convolution core computing per-channel partial sums for 4 filters in
//   parallel. An init pulse walks every input channel: the channel's 9 kernel
//   words are read from the internal weight ROM (LOAD), start_core_sim pulses
//   (START), then a 3x3 window slides over the internal square activation
//   image in raster order, one window per cycle (CONV). Each window yields
//   four 8-bit partial sums one cycle after it is presented.
//
//   Optional build macro: PSUM_SATURATE_EN
//     defined   -> a psum above 255 is clamped to 255
//     undefined -> psums are truncated mod 256
//
// Ports
//   clk_0, rst_0 (async, active low), en_0 (global freeze when low)
//   init_signal_0 : start pulse, only looked at in IDLE
//   addr_rst_0    : synchronous clear of the weight address counter
//   channel_0, stride_0, width_0, weight_size_0 : run configuration
//   BRAM_addr_weight, weight_end_0, weight_done : weight fetch status
//   weight0..3_sim : per-filter kernel, byte j = element j (row-major)
//   activate0..2_sim : current window rows, byte i = column i
//   start_core_sim : one-cycle pulse when a channel's kernel is loaded
//   out_psum0..3_0, out_psum_vld_0, channel_end_out : partial sum stream
//   o_dbg_state : FSM state (0 IDLE, 1 LOAD, 2 START, 3 CONV)
//
// Output stream handshake: out_psum_vld_0 is a strobe with no back-pressure;
// a psum is new on each rising edge where en_0 was high and vld is set.
// While en_0 is low every register, including vld, holds its value.
module convo_core (
  input  logic        clk_0,
  input  logic        rst_0,
  input  logic        en_0,
  input  logic        init_signal_0,
  input  logic        addr_rst_0,
  input  logic [11:0] channel_0,
  input  logic [2:0]  stride_0,
  input  logic [11:0] width_0,
  input  logic [31:0] weight_size_0,
  output logic [31:0] BRAM_addr_weight,
  output logic        weight_end_0,
  output logic        weight_done,
  output logic [71:0] weight0_sim,
  output logic [71:0] weight1_sim,
  output logic [71:0] weight2_sim,
  output logic [71:0] weight3_sim,
  output logic [23:0] activate0_sim,
  output logic [23:0] activate1_sim,
  output logic [23:0] activate2_sim,
  output logic        start_core_sim,
  output logic [7:0]  out_psum0_0,
  output logic [7:0]  out_psum1_0,
  output logic [7:0]  out_psum2_0,
  output logic [7:0]  out_psum3_0,
  output logic        out_psum_vld_0,
  output logic        channel_end_out,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_START = 2'd2, S_CONV = 2'd3} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [11:0]       r_ch;
  logic [3:0]        r_ld_cnt;
  logic [31:0]       r_addr;
  logic              r_wdone;
  logic [71:0]       r_wgt [4];
  logic [11:0]       r_ox, r_oy, r_x, r_r;
  logic              r_cur_last;
  logic [2:0][23:0]  r_act;
  logic [7:0]        r_psum [4];
  logic              r_vld;
  logic              r_chend;

  logic              w_cfg_ok;
  logic              w_go;
  logic [11:0]       w_stride;
  logic [11:0]       w_o;
  logic              w_last_win;
  logic              w_more_ch;
  logic [7:0]        w_base;
  logic [2:0][23:0]  w_win;
  logic [19:0]       w_sum [4];
  logic [7:0]        w_psum [4];
  logic [7:0]        w_rom [4];

  assign w_cfg_ok  = (width_0 >= 12'd3) && (stride_0 != 3'd0) && (channel_0 != 12'd0);
  assign w_go      = init_signal_0 && w_cfg_ok;
  // Guard the divider against stride 0; that configuration never starts a run.
  assign w_stride  = (stride_0 == 3'd0) ? 12'd1 : {9'd0, stride_0};
  assign w_o       = ((width_0 - 12'd3) / w_stride) + 12'd1;
  // Last window being presented next (counters point at the next window).
  assign w_last_win = (r_ox == w_o - 12'd1) && (r_oy == w_o - 12'd1);
  assign w_more_ch  = ({1'b0, r_ch} + 13'd1) < {1'b0, channel_0};

  // Window generator: only the low 8 bits of the activation formula matter.
  always_comb begin
    w_base = {r_ch[3:0], 4'b0000} + 8'(r_r[7:0] * width_0[7:0]) + r_x[7:0];
    w_win  = '0;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 3; i++) begin
        w_win[n][8*i +: 8] = w_base + 8'(8'(n) * width_0[7:0]) + 8'(i);
      end
    end
  end

  // Weight ROM word: filter k byte = address[7:0] + k.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_rom[k] = r_addr[7:0] + 8'(k);
    end
  end

  // Partial sums over the presented window, full width before reduction.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_sum[k] = '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          w_sum[k] = w_sum[k] + 20'(r_wgt[k][8*(3*i+j) +: 8]) * 20'(r_act[i][8*j +: 8]);
        end
      end
`ifdef PSUM_SATURATE_EN
      w_psum[k] = (w_sum[k] > 20'd255) ? 8'hFF : w_sum[k][7:0];
`else
      w_psum[k] = w_sum[k][7:0];
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_next = S_LOAD;
      S_LOAD:  if (r_ld_cnt == 4'd9) w_next = S_START;
      S_START: w_next = S_CONV;
      S_CONV:  if (r_cur_last) w_next = w_more_ch ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_0 or negedge rst_0) begin
    if (!rst_0) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_ld_cnt   <= '0;
      r_addr     <= '0;
      r_wdone    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_wgt[k]  <= '0;
        r_psum[k] <= '0;
      end
      r_ox       <= '0;
      r_oy       <= '0;
      r_x        <= '0;
      r_r        <= '0;
      r_cur_last <= 1'b0;
      r_act      <= '0;
      r_vld      <= 1'b0;
      r_chend    <= 1'b0;
    end else if (en_0) begin
      r_state <= w_next;
      r_vld   <= 1'b0;
      r_chend <= 1'b0;

      // Address counter: explicit clear wins over everything else.
      if (addr_rst_0) begin
        r_addr <= '0;
      end else if (r_state == S_IDLE && w_go) begin
        r_addr <= '0;
      end else if (r_state == S_LOAD && r_ld_cnt < 4'd9) begin
        r_addr <= r_addr + 32'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_wdone  <= 1'b0;
            r_ch     <= '0;
            r_ld_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (r_ld_cnt < 4'd9) begin
            // Registered ROM read: this cycle's word lands in element ld_cnt.
            for (int k = 0; k < 4; k++) begin
              for (int j = 0; j < 9; j++) begin
                if (r_ld_cnt == 4'(j)) r_wgt[k][8*j +: 8] <= w_rom[k];
              end
            end
            if (r_addr == weight_size_0 - 32'd1) r_wdone <= 1'b1;
            r_ld_cnt <= r_ld_cnt + 4'd1;
          end else begin
            r_ox       <= '0;
            r_oy       <= '0;
            r_x        <= '0;
            r_r        <= '0;
            r_cur_last <= 1'b0;
          end
        end
        S_START, S_CONV: begin
          if (r_state == S_CONV) begin
            for (int k = 0; k < 4; k++) r_psum[k] <= w_psum[k];
            r_vld   <= 1'b1;
            r_chend <= r_cur_last;
          end
          if (r_state == S_CONV && r_cur_last) begin
            r_ch     <= r_ch + 12'd1;
            r_ld_cnt <= '0;
          end else begin
            // Present the next window and advance the raster counters.
            r_act      <= w_win;
            r_cur_last <= w_last_win;
            if (r_ox == w_o - 12'd1) begin
              r_ox <= '0;
              r_x  <= '0;
              r_oy <= r_oy + 12'd1;
              r_r  <= r_r + w_stride;
            end else begin
              r_ox <= r_ox + 12'd1;
              r_x  <= r_x + w_stride;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign BRAM_addr_weight = r_addr;
  assign weight_end_0     = (r_addr == weight_size_0 - 32'd1);
  assign weight_done      = r_wdone;
  assign weight0_sim      = r_wgt[0];
  assign weight1_sim      = r_wgt[1];
  assign weight2_sim      = r_wgt[2];
  assign weight3_sim      = r_wgt[3];
  assign activate0_sim    = r_act[0];
  assign activate1_sim    = r_act[1];
  assign activate2_sim    = r_act[2];
  assign start_core_sim   = (r_state == S_START);
  assign out_psum0_0      = r_psum[0];
  assign out_psum1_0      = r_psum[1];
  assign out_psum2_0      = r_psum[2];
  assign out_psum3_0      = r_psum[3];
  assign out_psum_vld_0   = r_vld;
  assign channel_end_out  = r_chend;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_convo_core.sv
`timescale 1ns/1ps
module tb_convo_core;

  logic        clk_0 = 1'b0;
  logic        rst_0 = 1'b0;
  logic        en_0 = 1'b1;
  logic        init_signal_0 = 1'b0;
  logic        addr_rst_0 = 1'b0;
  logic [11:0] channel_0 = 12'd2;
  logic [2:0]  stride_0 = 3'd1;
  logic [11:0] width_0 = 12'd5;
  logic [31:0] weight_size_0 = 32'd18;
  logic [31:0] BRAM_addr_weight;
  logic        weight_end_0, weight_done;
  logic [71:0] weight0_sim, weight1_sim, weight2_sim, weight3_sim;
  logic [23:0] activate0_sim, activate1_sim, activate2_sim;
  logic        start_core_sim;
  logic [7:0]  out_psum0_0, out_psum1_0, out_psum2_0, out_psum3_0;
  logic        out_psum_vld_0, channel_end_out;
  logic [1:0]  o_dbg_state;

  convo_core dut (
    .clk_0(clk_0), .rst_0(rst_0), .en_0(en_0), .init_signal_0(init_signal_0),
    .addr_rst_0(addr_rst_0), .channel_0(channel_0), .stride_0(stride_0),
    .width_0(width_0), .weight_size_0(weight_size_0),
    .BRAM_addr_weight(BRAM_addr_weight), .weight_end_0(weight_end_0),
    .weight_done(weight_done), .weight0_sim(weight0_sim), .weight1_sim(weight1_sim),
    .weight2_sim(weight2_sim), .weight3_sim(weight3_sim),
    .activate0_sim(activate0_sim), .activate1_sim(activate1_sim),
    .activate2_sim(activate2_sim), .start_core_sim(start_core_sim),
    .out_psum0_0(out_psum0_0), .out_psum1_0(out_psum1_0),
    .out_psum2_0(out_psum2_0), .out_psum3_0(out_psum3_0),
    .out_psum_vld_0(out_psum_vld_0), .channel_end_out(channel_end_out),
    .o_dbg_state(o_dbg_state)
  );

  // clock
  always #5 clk_0 = ~clk_0;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  int          n_vld, n_start, n_chend, n_wend;
  int          chend_pos [2];
  logic        wdone_at_start [2];
  logic [23:0] first_a0, first_a1, first_a2, second_a0;
  logic [71:0] first_w0;
  logic [31:0] first_ps;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference psums for one window, straight from the activation/weight formulas.
  function automatic logic [31:0] ref_psums(int c, int oy, int ox, int w, int s);
    logic [31:0] res;
    int sum, wv, av;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      sum = 0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          wv = (9*c + 3*i + j + k) % 256;
          av = (16*c + (oy*s + i)*w + ox*s + j) % 256;
          sum += wv * av;
        end
      end
`ifdef PSUM_SATURATE_EN
      res[8*k +: 8] = (sum > 255) ? 8'hFF : 8'(sum);
`else
      res[8*k +: 8] = 8'(sum % 256);
`endif
    end
    return res;
  endfunction

  task automatic build_exp(input int nch, input int w, input int s);
    int o;
    o = (w - 3) / s + 1;
    exp_q.delete();
    for (int c = 0; c < nch; c++)
      for (int oy = 0; oy < o; oy++)
        for (int ox = 0; ox < o; ox++)
          exp_q.push_back(ref_psums(c, oy, ox, w, s));
  endtask

  // Pulse init, then watch the run until the core is back in IDLE.
  task automatic capture(input int max_cyc, input int pause_at, input int pause_len);
    logic [23:0] p0, p1, p2;
    logic [31:0] ps;
    logic        seen_busy, done;
    n_vld = 0; n_start = 0; n_chend = 0; n_wend = 0;
    chend_pos[0] = -1; chend_pos[1] = -1;
    wdone_at_start[0] = 1'bx; wdone_at_start[1] = 1'bx;
    seen_busy = 1'b0; done = 1'b0;
    init_signal_0 = 1'b1;
    @(negedge clk_0);
    init_signal_0 = 1'b0;
    p0 = activate0_sim; p1 = activate1_sim; p2 = activate2_sim;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      @(negedge clk_0);
      if (en_0) begin
        if (out_psum_vld_0) begin
          ps = {out_psum3_0, out_psum2_0, out_psum1_0, out_psum0_0};
          if (n_vld == 0) begin
            first_a0 = p0; first_a1 = p1; first_a2 = p2;
            first_w0 = weight0_sim; first_ps = ps;
          end
          if (n_vld == 1) second_a0 = p0;
          if (exp_q.size() > 0) check("psum_seq", 72'(ps), 72'(exp_q.pop_front()));
          else check("psum_extra", 72'(exp_q.size()), 72'd1);
          n_vld++;
          if (channel_end_out && n_chend < 2) chend_pos[n_chend] = n_vld;
        end
        if (channel_end_out) n_chend++;
        if (start_core_sim) begin
          if (n_start < 2) wdone_at_start[n_start] = weight_done;
          n_start++;
        end
        if (weight_end_0) n_wend++;
      end
      if (o_dbg_state != 2'd0) seen_busy = 1'b1;
      if (seen_busy && o_dbg_state == 2'd0 && !out_psum_vld_0) done = 1'b1;
      p0 = activate0_sim; p1 = activate1_sim; p2 = activate2_sim;
      if (pause_len > 0 && cyc == pause_at) en_0 = 1'b0;
      if (pause_len > 0 && cyc == pause_at + pause_len) en_0 = 1'b1;
    end
    en_0 = 1'b1;
    check("capture_done", 72'(done), 72'd1);
    check("psum_leftover", 72'(exp_q.size()), 72'd0);
  endtask

  initial begin
    int n;
    // reset state
    repeat (2) @(negedge clk_0);
    check("rst_state", 72'(o_dbg_state), 72'd0);
    check("rst_addr", 72'(BRAM_addr_weight), 72'd0);
    check("rst_vld", 72'(out_psum_vld_0), 72'd0);
    check("rst_psum0", 72'(out_psum0_0), 72'd0);
    check("rst_w0", weight0_sim, 72'd0);
    check("rst_act0", 72'(activate0_sim), 72'd0);
    check("rst_start", 72'(start_core_sim), 72'd0);
    check("rst_wdone", 72'(weight_done), 72'd0);
    check("rst_wend", 72'(weight_end_0), 72'd0);
    check("rst_chend", 72'(channel_end_out), 72'd0);
    rst_0 = 1'b1;
    @(negedge clk_0);

    // width 5, stride 1, two channels
    build_exp(2, 5, 1);
    capture(100, 0, 0);
    check("r1_vld_count", 72'(n_vld), 72'd18);
    check("r1_start_count", 72'(n_start), 72'd2);
    check("r1_chend_count", 72'(n_chend), 72'd2);
    check("r1_chend_pos0", 72'(chend_pos[0]), 72'd9);
    check("r1_chend_pos1", 72'(chend_pos[1]), 72'd18);
    check("r1_wdone_start0", 72'(wdone_at_start[0]), 72'd0);
    check("r1_wdone_start1", 72'(wdone_at_start[1]), 72'd1);
    check("r1_wdone_end", 72'(weight_done), 72'd1);
    check("r1_wend_count", 72'(n_wend), 72'd1);
    check("r1_first_act0", 72'(first_a0), 72'h020100);
    check("r1_first_act1", 72'(first_a1), 72'h070605);
    check("r1_first_act2", 72'(first_a2), 72'h0C0B0A);
    check("r1_first_w0", first_w0, 72'h080706050403020100);
`ifdef PSUM_SATURATE_EN
    check("r1_first_psum0", 72'(first_ps[7:0]), 72'd255);
    check("r1_first_psum1", 72'(first_ps[15:8]), 72'd255);
`else
    check("r1_first_psum0", 72'(first_ps[7:0]), 72'd56);
    check("r1_first_psum1", 72'(first_ps[15:8]), 72'd110);
`endif
    check("r1_addr_end", 72'(BRAM_addr_weight), 72'd18);

    // address clear from IDLE
    addr_rst_0 = 1'b1;
    @(negedge clk_0);
    addr_rst_0 = 1'b0;
    check("addr_rst_idle", 72'(BRAM_addr_weight), 72'd0);

    // width 7, stride 2, one channel
    width_0 = 12'd7; stride_0 = 3'd2; channel_0 = 12'd1; weight_size_0 = 32'd9;
    build_exp(1, 7, 2);
    capture(100, 0, 0);
    check("r2_vld_count", 72'(n_vld), 72'd9);
    check("r2_second_act0", 72'(second_a0), 72'h040302);
    check("r2_chend_count", 72'(n_chend), 72'd1);
    check("r2_start_count", 72'(n_start), 72'd1);

    // enable dropped for 5 cycles in the middle of CONV
    width_0 = 12'd5; stride_0 = 3'd1; channel_0 = 12'd2; weight_size_0 = 32'd18;
    build_exp(2, 5, 1);
    capture(120, 14, 5);
    check("r3_vld_count", 72'(n_vld), 72'd18);
    check("r3_chend_count", 72'(n_chend), 72'd2);

    // width below kernel size: init ignored
    width_0 = 12'd2;
    init_signal_0 = 1'b1;
    @(negedge clk_0);
    init_signal_0 = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_0);
      if (out_psum_vld_0 || o_dbg_state != 2'd0) n++;
    end
    check("w2_stays_idle", 72'(n), 72'd0);

    // asynchronous reset during LOAD
    width_0 = 12'd5;
    init_signal_0 = 1'b1;
    @(negedge clk_0);
    init_signal_0 = 1'b0;
    repeat (4) @(negedge clk_0);
    check("pre_rst_load", 72'(o_dbg_state), 72'd1);
    check("pre_rst_w0_loaded", 72'(weight0_sim != 72'd0), 72'd1);
    #2 rst_0 = 1'b0;
    #1;
    check("mid_rst_state", 72'(o_dbg_state), 72'd0);
    check("mid_rst_addr", 72'(BRAM_addr_weight), 72'd0);
    check("mid_rst_w0", weight0_sim, 72'd0);
    check("mid_rst_w1", weight1_sim, 72'd0);
    check("mid_rst_vld", 72'(out_psum_vld_0), 72'd0);
    @(negedge clk_0);
    rst_0 = 1'b1;
    @(negedge clk_0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
